// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier (signed MULT / unsigned MULTU) with a start/busy/done handshake.
// The 2*WIDTH-bit result is {HI, LO}; one partial-product step is taken per cycle, with no early exit.
module seq_mul_unit #(
    parameter int unsigned WIDTH = 32,
    parameter logic [5:0]  MULT  = 6'b011000,
    parameter logic [5:0]  MULTU = 6'b011001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           Signal,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_mcand;
    logic [PW-1:0]     w_mcand_nxt;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     w_acc_nxt;
    logic [PW-1:0]     r_data_out;
    logic [PW-1:0]     w_data_out_nxt;
    logic [WIDTH-1:0]  r_mplier;
    logic [WIDTH-1:0]  w_mplier_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_neg;
    logic              w_neg_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_is_mult;
    logic              w_is_multu;
    logic              w_accept;
    logic [WIDTH-1:0]  w_abs_a;
    logic [WIDTH-1:0]  w_abs_b;

    assign w_is_mult  = (Signal == MULT);
    assign w_is_multu = (Signal == MULTU);
    assign w_accept   = (r_state == S_IDLE) && start && (w_is_mult || w_is_multu);

    // Unsigned W-bit magnitude: the most negative value maps onto 2^(W-1) without overflow.
    assign w_abs_a = dataA[WIDTH-1] ? (~dataA + WIDTH'(1)) : dataA;
    assign w_abs_b = dataB[WIDTH-1] ? (~dataB + WIDTH'(1)) : dataB;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        w_mcand_nxt    = r_mcand;
        w_mplier_nxt   = r_mplier;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_neg_nxt      = r_neg;
        w_data_out_nxt = r_data_out;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_mcand_nxt  = PW'(w_is_mult ? w_abs_a : dataA);
                    w_mplier_nxt = w_is_mult ? w_abs_b : dataB;
                    w_neg_nxt    = w_is_mult && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = CW'(WIDTH);
                end
            end
            S_RUN: begin
                if (r_mplier[0]) w_acc_nxt = r_acc + r_mcand;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt - CW'(1);
            end
            S_FIX: begin
                w_data_out_nxt = r_neg ? (~r_acc + PW'(1)) : r_acc;
                w_done_nxt     = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_mcand    <= w_mcand_nxt;
            r_mplier   <= w_mplier_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_neg      <= w_neg_nxt;
            r_data_out <= w_data_out_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dataOut = r_data_out;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed bench for seq_mul_unit at WIDTH=32 and WIDTH=8.
// Expected products are queued at issue time and popped when done is seen.
module tb_seq_mul_unit;

    localparam logic [5:0] C_MULT  = 6'b011000;
    localparam logic [5:0] C_MULTU = 6'b011001;
    localparam int         W32     = 32;
    localparam int         W8      = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start8;
    logic [5:0]  sig32, sig8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, busy8, done8;
    logic [63:0] out32;
    logic [15:0] out8;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] q32[$];
    logic [63:0] q8[$];

    always #5 clk = ~clk;

    seq_mul_unit #(.WIDTH(W32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .Signal(sig32),
        .dataA(a32), .dataB(b32), .busy(busy32), .done(done32), .dataOut(out32)
    );

    seq_mul_unit #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .Signal(sig8),
        .dataA(a8), .dataB(b8), .busy(busy8), .done(done8), .dataOut(out8)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Reference product from native wide multiplication, truncated to 2w bits.
    function automatic logic [63:0] model(input logic [5:0] sig, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        if (w == 8) begin
            sa = 64'($signed(a[7:0]));
            sb = 64'($signed(b[7:0]));
            ua = 64'(a[7:0]);
            ub = 64'(b[7:0]);
        end else begin
            sa = 64'($signed(a));
            sb = 64'($signed(b));
            ua = 64'(a);
            ub = 64'(b);
        end
        p = (sig == C_MULT) ? 64'(sa * sb) : (ua * ub);
        if (w == 8) p = {48'h0, p[15:0]};
        return p;
    endfunction

    function automatic logic cur_done(input bit s8);
        return s8 ? done8 : done32;
    endfunction

    function automatic logic cur_busy(input bit s8);
        return s8 ? busy8 : busy32;
    endfunction

    function automatic logic [63:0] cur_out(input bit s8);
        return s8 ? {48'h0, out8} : out32;
    endfunction

    // Drive one start pulse across one clock edge; returns 1 time unit after that edge.
    task automatic start_op(input bit s8, input logic [5:0] sig, input logic [31:0] a,
                            input logic [31:0] b, input bit push_exp);
        if (s8) begin
            start8 = 1'b1; sig8 = sig; a8 = a[7:0]; b8 = b[7:0];
            if (push_exp) q8.push_back(model(sig, a, b, W8));
        end else begin
            start32 = 1'b1; sig32 = sig; a32 = a; b32 = b;
            if (push_exp) q32.push_back(model(sig, a, b, W32));
        end
        @(posedge clk); #1;
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    // Wait (bounded) for done; check latency, busy while pending, output hold, and the result.
    task automatic wait_done(input bit s8, input int lat_exp, input string name);
        int          cyc      = 0;
        int          busy_bad = 0;
        int          hold_bad = 0;
        bit          seen     = 1'b0;
        logic [63:0] held     = cur_out(s8);
        logic [63:0] exp;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cur_done(s8)) begin
                seen = 1'b1;
                break;
            end
            if (!cur_busy(s8)) busy_bad++;
            if (cur_out(s8) !== held) hold_bad++;
        end
        check({name, " done_seen"}, 64'(seen), 64'd1);
        check({name, " latency"}, 64'(cyc), 64'(lat_exp));
        check({name, " busy_gaps"}, 64'(busy_bad), 64'd0);
        check({name, " hold_violations"}, 64'(hold_bad), 64'd0);
        if (s8) exp = (q8.size() > 0) ? q8.pop_front() : 'x;
        else    exp = (q32.size() > 0) ? q32.pop_front() : 'x;
        check({name, " dataOut"}, cur_out(s8), exp);
        check({name, " busy_after_done"}, 64'(cur_busy(s8)), 64'd0);
    endtask

    // Count done and busy assertions over n cycles (used when nothing should happen).
    task automatic idle_watch(input bit s8, input int n, output int n_done, output int n_busy);
        n_done = 0;
        n_busy = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (cur_done(s8)) n_done++;
            if (cur_busy(s8)) n_busy++;
        end
    endtask

    initial begin
        int          nd, nb;
        logic [63:0] prev;

        reset = 1'b0;
        start32 = 1'b0; sig32 = '0; a32 = '0; b32 = '0;
        start8  = 1'b0; sig8  = '0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy32", 64'(busy32), 64'd0);
        check("rst done32", 64'(done32), 64'd0);
        check("rst out32", out32, 64'd0);
        check("rst busy8", 64'(busy8), 64'd0);
        check("rst done8", 64'(done8), 64'd0);
        check("rst out8", 64'(out8), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Unsigned maximum, with busy checked right after acceptance
        start_op(1'b0, C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("multu_max busy_on_accept", 64'(busy32), 64'd1);
        wait_done(1'b0, W32 + 1, "multu_max");
        check("multu_max literal", out32, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;
        check("multu_max done_width", 64'(done32), 64'd0);

        // Signed combinations and extremes
        start_op(1'b0, C_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done(1'b0, W32 + 1, "mult_m3x7");
        start_op(1'b0, C_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1);
        wait_done(1'b0, W32 + 1, "mult_m3xm7");
        start_op(1'b0, C_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(1'b0, W32 + 1, "mult_min_sq");
        check("mult_min_sq literal", out32, 64'h4000_0000_0000_0000);
        start_op(1'b0, C_MULTU, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(1'b0, W32 + 1, "multu_half_sq");
        start_op(1'b0, C_MULT, 32'd0, 32'hFFFF_FFFB, 1'b1);
        wait_done(1'b0, W32 + 1, "mult_zero_neg");

        // Start while busy is ignored
        start_op(1'b0, C_MULTU, 32'd10, 32'd10, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        start32 = 1'b1; sig32 = C_MULTU; a32 = 32'd2; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        check("busy_ignore busy", 64'(busy32), 64'd1);
        wait_done(1'b0, W32 + 1 - 4, "busy_ignore");

        // Unsupported function code in IDLE
        prev = out32;
        start_op(1'b0, 6'b011010, 32'd9, 32'd9, 1'b0);
        check("bad_code busy", 64'(busy32), 64'd0);
        idle_watch(1'b0, W32 + 4, nd, nb);
        check("bad_code done_count", 64'(nd), 64'd0);
        check("bad_code busy_count", 64'(nb), 64'd0);
        check("bad_code out_held", out32, prev);

        // Back-to-back: second start issued while done is high for the first
        start_op(1'b0, C_MULTU, 32'd4, 32'd4, 1'b1);
        wait_done(1'b0, W32 + 1, "b2b_first");
        start_op(1'b0, C_MULTU, 32'd6, 32'd9, 1'b1);
        check("b2b done_width", 64'(done32), 64'd0);
        check("b2b busy", 64'(busy32), 64'd1);
        check("b2b out_held", out32, 64'd16);
        wait_done(1'b0, W32 + 1, "b2b_second");

        // Reset in the middle of RUN
        start_op(1'b0, C_MULTU, 32'd5, 32'd7, 1'b1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy32), 64'd0);
        check("midrst out", out32, 64'd0);
        check("midrst done", 64'(done32), 64'd0);
        q32.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle_watch(1'b0, W32 + 8, nd, nb);
        check("midrst no_done", 64'(nd), 64'd0);
        check("midrst no_busy", 64'(nb), 64'd0);
        start_op(1'b0, C_MULTU, 32'd5, 32'd7, 1'b1);
        wait_done(1'b0, W32 + 1, "after_rst");
        check("after_rst literal", out32, 64'd35);

        // Narrow instance
        start_op(1'b1, C_MULT, 32'h80, 32'h80, 1'b1);
        wait_done(1'b1, W8 + 1, "w8_mult_min_sq");
        check("w8_mult_min_sq literal", 64'(out8), 64'h4000);
        start_op(1'b1, C_MULTU, 32'hFF, 32'hFF, 1'b1);
        wait_done(1'b1, W8 + 1, "w8_multu_max");
        check("w8_multu_max literal", 64'(out8), 64'hFE01);
        start_op(1'b1, C_MULT, 32'h85, 32'h13, 1'b1);
        wait_done(1'b1, W8 + 1, "w8_mult_mixed");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
